// File: rtl/breath_scheduler_if.sv
// Configuration write port of the breathing-light sequencer.
// The requester (host or button decoder) drives a table entry and holds
// cfg_valid until the sequencer, idle, raises cfg_ready.
interface breath_scheduler_if #(
  parameter int AW = 3
);
  logic          cfg_valid;
  logic          cfg_ready;
  logic [AW-1:0] cfg_addr;
  logic [23:0]   cfg_data;

  modport master (
    output cfg_valid, cfg_addr, cfg_data,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_addr, cfg_data,
    output cfg_ready
  );
endinterface

// File: rtl/breath_scheduler.sv
// breath_scheduler: steps through a table of per-channel RGB ramp
// coefficients, one breath per entry (LOAD, saturating ramp up, ramp down,
// dark gap), and drives registered 8-bit duties to the PWM generators.

// One colour channel: next duty for a ramp-up and for a ramp-down edge.
module breath_lane (
  input  logic [7:0] duty_i,
  input  logic [7:0] coef_i,
  output logic [7:0] up_o,
  output logic [7:0] dn_o
);
  logic [8:0] sum;

  // 9-bit sum so a carry out pins the channel at full scale instead of wrapping
  assign sum  = {1'b0, duty_i} + {1'b0, coef_i};
  assign up_o = sum[8] ? 8'hFF : sum[7:0];
  // floor at zero on the way down
  assign dn_o = (duty_i >= coef_i) ? (duty_i - coef_i) : 8'h00;
endmodule

module breath_scheduler #(
  parameter  int STEPS    = 8,
  parameter  int RAMP_LEN = 32,
  parameter  int GAP_LEN  = 4,
  localparam int AW       = $clog2(STEPS)
) (
  input  logic              clk_div,
  input  logic              rst,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              loop_i,
  input  logic [AW-1:0]     last_step_i,
  breath_scheduler_if.slave cfg,
  output logic [7:0]        r_duty_o,
  output logic [7:0]        g_duty_o,
  output logic [7:0]        b_duty_o,
  output logic [AW-1:0]     step_idx_o,
  output logic              busy_o,
  output logic              step_done_o
);
  localparam int NCH    = 3;
  localparam int MAXLEN = (RAMP_LEN > GAP_LEN) ? RAMP_LEN : GAP_LEN;
  localparam int CW     = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
  localparam logic [CW-1:0] RAMP_RLD = CW'(RAMP_LEN - 1);
  localparam logic [CW-1:0] GAP_RLD  = CW'(GAP_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_UP,
    S_DOWN,
    S_GAP
  } state_e;

  state_e                   state_q;
  logic [CW-1:0]            cnt_q;
  logic [NCH-1:0][7:0]      duty_q;
  logic [NCH-1:0][7:0]      coef_q;
  logic [NCH-1:0][7:0]      up_d;
  logic [NCH-1:0][7:0]      dn_d;
  logic [AW-1:0]            idx_q;
  logic [AW-1:0]            last_q;
  logic                     done_q;
  logic [23:0]              tbl_q [STEPS];
  logic                     cfg_rdy;

  // Writes are only taken while idle so a running breath never sees a table change
  assign cfg_rdy       = (state_q == S_IDLE);
  assign cfg.cfg_ready = cfg_rdy;
  assign busy_o        = !cfg_rdy;

  // Channel 2/1/0 = R/G/B, matching the packing of cfg_data
  for (genvar c = 0; c < NCH; c++) begin : g_lane
    breath_lane u_lane (
      .duty_i (duty_q[c]),
      .coef_i (coef_q[c]),
      .up_o   (up_d[c]),
      .dn_o   (dn_d[c])
    );
  end

  // Coefficient table: written from the cfg port, cleared by reset
  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STEPS; i++) tbl_q[i] <= '0;
    end else if (cfg.cfg_valid && cfg_rdy) begin
      tbl_q[cfg.cfg_addr] <= cfg.cfg_data;
    end
  end

  // Sequencer FSM with registered duties, step index and step_done pulse
  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      duty_q  <= '0;
      coef_q  <= '0;
      idx_q   <= '0;
      last_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          duty_q <= '0;
          if (start_i && !stop_i) begin
            last_q  <= last_step_i;
            idx_q   <= '0;
            cnt_q   <= '0;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          coef_q  <= tbl_q[idx_q];
          duty_q  <= '0;
          cnt_q   <= RAMP_RLD;
          state_q <= S_UP;
        end
        S_UP: begin
          duty_q <= up_d;
          if (cnt_q == '0) begin
            cnt_q   <= RAMP_RLD;
            state_q <= S_DOWN;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_DOWN: begin
          duty_q <= dn_d;
          if (cnt_q == '0) begin
            cnt_q   <= GAP_RLD;
            state_q <= S_GAP;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        S_GAP: begin
          duty_q <= '0;
          if (cnt_q == '0) begin
            done_q <= 1'b1;
            cnt_q  <= '0;
            if (idx_q != last_q) begin
              idx_q   <= idx_q + AW'(1);
              state_q <= S_LOAD;
            end else if (loop_i) begin
              idx_q   <= '0;
              state_q <= S_LOAD;
            end else begin
              // natural end keeps the final index visible
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
      // abort beats every other transition, including the end-of-step pulse
      if (stop_i && (state_q != S_IDLE)) begin
        state_q <= S_IDLE;
        duty_q  <= '0;
        idx_q   <= '0;
        cnt_q   <= '0;
        done_q  <= 1'b0;
      end
    end
  end

  assign r_duty_o    = duty_q[2];
  assign g_duty_o    = duty_q[1];
  assign b_duty_o    = duty_q[0];
  assign step_idx_o  = idx_q;
  assign step_done_o = done_q;
endmodule

// File: tb/tb_breath_scheduler.sv
// Bench for breath_scheduler: a per-cycle reference model that tracks the
// position inside each breath and derives duties in closed form, plus
// hand-computed directed checks.
module tb_breath_scheduler;
  localparam int STEPS = 8;
  localparam int AW    = 3;
  localparam int RL    = 32;
  localparam int GL    = 4;
  localparam int PER   = 1 + 2 * RL + GL;

  logic          clk_div = 1'b0;
  logic          rst     = 1'b1;
  logic          start   = 1'b0;
  logic          stop    = 1'b0;
  logic          loop    = 1'b0;
  logic [AW-1:0] last_step = '0;
  logic [7:0]    r_duty, g_duty, b_duty;
  logic [AW-1:0] step_idx;
  logic          busy, step_done;

  int vecs = 0;
  int errs = 0;
  bit chk_en = 1'b0;

  breath_scheduler_if #(.AW(AW)) cif();

  breath_scheduler #(.STEPS(STEPS), .RAMP_LEN(RL), .GAP_LEN(GL)) dut (
    .clk_div     (clk_div),
    .rst         (rst),
    .start_i     (start),
    .stop_i      (stop),
    .loop_i      (loop),
    .last_step_i (last_step),
    .cfg         (cif),
    .r_duty_o    (r_duty),
    .g_duty_o    (g_duty),
    .b_duty_o    (b_duty),
    .step_idx_o  (step_idx),
    .busy_o      (busy),
    .step_done_o (step_done)
  );

  always #5 clk_div = ~clk_div;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_div);
  endtask

  // ---------------- reference model ----------------
  logic [23:0]   m_tbl [STEPS];
  bit            m_busy = 1'b0;
  bit            m_done = 1'b0;
  int            m_pos  = 0;     // cycle within the current breath, 0 = LOAD
  logic [AW-1:0] m_idx  = '0;
  logic [AW-1:0] m_last = '0;

  // Duty seen during cycle `pos` of a breath with coefficient c
  function automatic logic [7:0] exp_duty(input int pos, input int c);
    int peak;
    int v;
    peak = (c * RL > 255) ? 255 : c * RL;
    if (pos == 0) v = 0;
    else if (pos <= RL) v = (c * (pos - 1) > 255) ? 255 : c * (pos - 1);
    else if (pos <= 2 * RL + 1) begin
      v = peak - c * (pos - RL - 1);
      if (v < 0) v = 0;
    end else v = 0;
    return 8'(v);
  endfunction

  // Model advances on each edge from the inputs held across it
  always @(posedge clk_div or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STEPS; i++) m_tbl[i] = '0;
      m_busy = 1'b0; m_done = 1'b0; m_pos = 0; m_idx = '0; m_last = '0;
    end else begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (cif.cfg_valid) m_tbl[cif.cfg_addr] = cif.cfg_data;
        if (start && !stop) begin
          m_busy = 1'b1; m_pos = 0; m_idx = '0; m_last = last_step;
        end
      end else if (stop) begin
        m_busy = 1'b0; m_idx = '0;
      end else begin
        m_pos++;
        if (m_pos == PER) begin
          m_done = 1'b1;
          m_pos  = 0;
          if (m_idx != m_last) m_idx = m_idx + 1'b1;
          else if (loop) m_idx = '0;
          else m_busy = 1'b0;
        end
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk_div) begin : cmp
    logic [23:0] cf;
    if (chk_en) begin
      cf = m_tbl[m_idx];
      chk("m_r_duty", r_duty, m_busy ? exp_duty(m_pos, int'(cf[23:16])) : 8'h00);
      chk("m_g_duty", g_duty, m_busy ? exp_duty(m_pos, int'(cf[15:8]))  : 8'h00);
      chk("m_b_duty", b_duty, m_busy ? exp_duty(m_pos, int'(cf[7:0]))   : 8'h00);
      chk("m_step_idx", step_idx, m_idx);
      chk("m_busy", busy, m_busy);
      chk("m_cfg_ready", cif.cfg_ready, !m_busy);
      chk("m_step_done", step_done, m_done);
    end
  end

  task automatic wr(input logic [AW-1:0] a, input logic [23:0] d);
    cif.cfg_valid = 1'b1; cif.cfg_addr = a; cif.cfg_data = d;
    tick(1);
    cif.cfg_valid = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    cif.cfg_valid = 1'b0; cif.cfg_addr = '0; cif.cfg_data = '0;
    tick(3);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cif.cfg_ready, 1);
    chk("rst_r", r_duty, 0);
    chk("rst_idx", step_idx, 0);
    chk("rst_done", step_done, 0);
    rst = 1'b0;
    chk_en = 1'b1;
    tick(2);

    // single breath, saturation and exact return to zero
    wr(0, 24'h080300);
    last_step = 0; loop = 1'b0; start = 1'b1;
    tick(1); start = 1'b0;                      // LOAD cycle
    tick(32); chk("up31_r", r_duty, 8'hF8);
    tick(1);  chk("up32_r_sat", r_duty, 8'hFF);
    chk("g_peak", g_duty, 8'h60);
    chk("b_zero", b_duty, 8'h00);
    tick(31); chk("dn31_r", r_duty, 8'h07);
    tick(1);  chk("dn32_r", r_duty, 8'h00); chk("dn32_g", g_duty, 8'h00);
    tick(3);  chk("gap_end_busy", busy, 1); chk("gap_end_done", step_done, 0);
    tick(1);  chk("end_busy", busy, 0); chk("end_done", step_done, 1);
    tick(1);  chk("end_done_clr", step_done, 0);
    tick(2);

    // three looping entries, blocked write while busy, then stop mid-UP
    wr(0, 24'h102030); wr(1, 24'h050A0F); wr(2, 24'hFF0001);
    last_step = 2; loop = 1'b1; start = 1'b1;
    tick(1); start = 1'b0;                      // c = 0
    tick(10); chk("seq0", step_idx, 0);         // c = 10
    tick(59); chk("done_69", step_done, 1);     // c = 69
    tick(10); chk("seq1", step_idx, 1);         // c = 79
    tick(21);                                   // c = 100
    cif.cfg_valid = 1'b1; cif.cfg_addr = 1; cif.cfg_data = 24'h010205;
    chk("busy_ready", cif.cfg_ready, 0);
    tick(48); chk("seq2", step_idx, 2);         // c = 148
    tick(59); chk("done_207", step_done, 1);    // c = 207
    tick(10); chk("seq3", step_idx, 0);         // c = 217
    tick(69); chk("seq4", step_idx, 1);         // c = 286, step 1 mid-UP
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("stop_busy", busy, 0); chk("stop_r", r_duty, 0); chk("stop_b", b_duty, 0);
    chk("stop_idx", step_idx, 0); chk("stop_done", step_done, 0);
    tick(1);                                    // held write landed on first idle edge
    cif.cfg_valid = 1'b0;
    tick(1);

    // start and stop together while idle
    start = 1'b1; stop = 1'b1;
    tick(1);
    start = 1'b0; stop = 1'b0;
    chk("start_stop_idle", busy, 0);
    tick(1);

    // write and start on the same edge; step 1 uses the deferred write
    cif.cfg_valid = 1'b1; cif.cfg_addr = 0; cif.cfg_data = 24'h400010;
    last_step = 1; loop = 1'b0; start = 1'b1;
    tick(1); cif.cfg_valid = 1'b0; start = 1'b0;
    tick(4);  chk("new0_r", r_duty, 8'hC0); chk("new0_b", b_duty, 8'h30);
    tick(1);  chk("new0_r_sat", r_duty, 8'hFF);
    tick(97); chk("new1_r", r_duty, 8'h20); chk("new1_g", g_duty, 8'h40);
    chk("new1_b", b_duty, 8'hA0); chk("new1_idx", step_idx, 1);
    tick(36); chk("new_end_busy", busy, 0); chk("new_end_done", step_done, 1);
    tick(2);

    // asynchronous reset during DOWN clears outputs and table
    last_step = 0; loop = 1'b0; start = 1'b1;
    tick(1); start = 1'b0;
    tick(34); chk("pre_rst_r", r_duty, 8'hBF); chk("pre_rst_b", b_duty, 8'hEF);
    #2 rst = 1'b1;
    #1;
    chk("arst_r", r_duty, 0); chk("arst_g", g_duty, 0); chk("arst_b", b_duty, 0);
    chk("arst_busy", busy, 0); chk("arst_ready", cif.cfg_ready, 1);
    chk("arst_idx", step_idx, 0); chk("arst_done", step_done, 0);
    tick(2);
    rst = 1'b0;
    tick(1);
    start = 1'b1;
    tick(1); start = 1'b0;
    tick(20); chk("zero_tbl_r", r_duty, 0); chk("zero_tbl_b", b_duty, 0);
    chk("zero_tbl_busy", busy, 1);
    tick(60);
    chk("final_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
